signed_result_display: RTL and testbench

- Sequential display decoder for the 10-bit two's-complement result bus produced by the signed calculator datapath (op).
- Converts one sampled result into a sign flag plus three BCD digits using an iterative shift-add-3 algorithm.
- Drives a 4-digit, time-multiplexed seven-segment display showing the sign, hundreds, tens and ones digits.
- Sits between the calculator output and the board display.

---
 rtl/signed_result_display_pkg.sv | 58 +++++
 rtl/signed_result_display_seg7_encoder.sv | 16 +
 rtl/signed_result_display.sv | 170 +++++++++++++++++
 tb/tb_signed_result_display.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/signed_result_display_pkg.sv
// Shared types and constants for the signed result display decoder:
// FSM encoding, seven-segment codes and the double-dabble adjust step.
package signed_result_display_pkg;

  localparam int DATA_W = 10;
  localparam int NDIG   = 3;
  localparam int BCD_W  = 4 * NDIG;

  localparam logic [3:0] SHIFT_CYCLES = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next shift.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] scratch);
    logic [BCD_W-1:0] adj;
    adj = scratch;
    for (int i = 0; i < NDIG; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    return adj;
  endfunction

endpackage

// File: rtl/signed_result_display_seg7_encoder.sv
// Combinational BCD digit to seven-segment encoder {g,f,e,d,c,b,a}, with a
// blank override used for leading-zero suppression.
module signed_result_display_seg7_encoder
  import signed_result_display_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) o_seg = digit_to_seg(i_digit);
  end

endmodule

// File: rtl/signed_result_display.sv
// Converts a sampled 10-bit signed result to sign + three BCD digits
// (shift-add-3) and scans them onto a 4-digit seven-segment display.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | ten double-dabble shift cycles on the captured magnitude
// DONE  | publish digits and sign, pulse done, return to IDLE
module signed_result_display
  import signed_result_display_pkg::*;
#(
  parameter int SCAN_DIV       = 1024,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_op,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_sign,
  output logic [3:0]        o_bcd_hund,
  output logic [3:0]        o_bcd_tens,
  output logic [3:0]        o_bcd_ones,
  output logic [6:0]        o_seg,
  output logic [3:0]        o_an
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

  state_t            r_state;
  logic [3:0]        r_count;
  logic [DATA_W-1:0] r_mag;
  logic [BCD_W-1:0]  r_scratch;
  logic              r_sign_cap;
  logic              r_busy;
  logic              r_done;
  logic              r_sign;
  logic [3:0]        r_bcd_hund;
  logic [3:0]        r_bcd_tens;
  logic [3:0]        r_bcd_ones;

  logic [CNT_W-1:0]  r_scan_cnt;
  logic [1:0]        r_scan_idx;
  logic [6:0]        r_seg;
  logic [3:0]        r_an;

  logic [DATA_W-1:0] w_mag_abs;
  logic [BCD_W-1:0]  w_scratch_adj;
  logic              w_scan_wrap;
  logic [1:0]        w_idx_next;
  logic [3:0]        w_enc_digit;
  logic              w_enc_blank;
  logic [6:0]        w_enc_seg;
  logic [6:0]        w_seg_next;

  // |op| as unsigned DATA_W bits: -512 negates to 10'h200, which reads as 512.
  assign w_mag_abs     = i_op[DATA_W-1] ? (~i_op + DATA_W'(1)) : i_op;
  assign w_scratch_adj = dabble_adjust(r_scratch);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_mag      <= '0;
      r_scratch  <= '0;
      r_sign_cap <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sign     <= 1'b0;
      r_bcd_hund <= '0;
      r_bcd_tens <= '0;
      r_bcd_ones <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_sign_cap <= i_op[DATA_W-1];
            r_mag      <= w_mag_abs;
            r_scratch  <= '0;
            r_count    <= SHIFT_CYCLES;
            r_busy     <= 1'b1;
            r_state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_scratch <= (w_scratch_adj << 1) | BCD_W'(r_mag[DATA_W-1]);
          r_mag     <= r_mag << 1;
          r_count   <= r_count - 4'd1;
          if (r_count == 4'd1) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_bcd_hund <= r_scratch[11:8];
          r_bcd_tens <= r_scratch[7:4];
          r_bcd_ones <= r_scratch[3:0];
          r_sign     <= r_sign_cap;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_scan_wrap = (r_scan_cnt == SCAN_LAST);
  assign w_idx_next  = w_scan_wrap ? r_scan_idx + 2'd1 : r_scan_idx;

  // Leading-zero suppression: hundreds blank when 0, tens blank when both are 0.
  always_comb begin
    w_enc_digit = r_bcd_ones;
    w_enc_blank = 1'b0;
    case (w_idx_next)
      2'd1: begin
        w_enc_digit = r_bcd_tens;
        w_enc_blank = (r_bcd_hund == 4'd0) && (r_bcd_tens == 4'd0);
      end
      2'd2: begin
        w_enc_digit = r_bcd_hund;
        w_enc_blank = (r_bcd_hund == 4'd0);
      end
      2'd3: begin
        w_enc_digit = 4'd0;
        w_enc_blank = 1'b1;
      end
      default: begin
        w_enc_digit = r_bcd_ones;
        w_enc_blank = 1'b0;
      end
    endcase
  end

  signed_result_display_seg7_encoder u_seg7 (
    .i_digit (w_enc_digit),
    .i_blank (w_enc_blank),
    .o_seg   (w_enc_seg)
  );

  assign w_seg_next = (w_idx_next == 2'd3) ? (r_sign ? SEG_MINUS : SEG_BLANK) : w_enc_seg;

  // seg/an are rebuilt every cycle from the next index, so they change on the
  // same edge as the index and pick up new digits without waiting for a wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scan_cnt <= '0;
      r_scan_idx <= '0;
      r_seg      <= SEG_0;
      r_an       <= 4'b0001;
    end else begin
      r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + CNT_W'(1);
      r_scan_idx <= w_idx_next;
      r_an       <= 4'b0001 << w_idx_next;
      r_seg      <= w_seg_next;
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_sign     = r_sign;
  assign o_bcd_hund = r_bcd_hund;
  assign o_bcd_tens = r_bcd_tens;
  assign o_bcd_ones = r_bcd_ones;
  assign o_seg      = SEG_ACTIVE_LOW ? ~r_seg : r_seg;
  assign o_an       = SEG_ACTIVE_LOW ? ~r_an  : r_an;

endmodule

// File: tb/tb_signed_result_display.sv
// Self-checking bench: table vectors, random ops against an arithmetic
// reference, start-while-busy, mid-conversion reset and display scanning.
module tb_signed_result_display;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] op;

  logic       busy_a, done_a, sign_a;
  logic [3:0] hund_a, tens_a, ones_a, an_a;
  logic [6:0] seg_a;
  logic       busy_b, done_b, sign_b;
  logic [3:0] hund_b, tens_b, ones_b, an_b;
  logic [6:0] seg_b;

  int checks   = 0;
  int failures = 0;
  int unsigned ncyc;

  localparam logic [6:0] SEG_TBL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  typedef struct {
    logic [9:0] op;
    bit         sgn;
    int         h;
    int         t;
    int         o;
  } vec_t;

  vec_t vecs [11];

  signed_result_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op),
    .o_busy(busy_a), .o_done(done_a), .o_sign(sign_a),
    .o_bcd_hund(hund_a), .o_bcd_tens(tens_a), .o_bcd_ones(ones_a),
    .o_seg(seg_a), .o_an(an_a)
  );

  signed_result_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op),
    .o_busy(busy_b), .o_done(done_b), .o_sign(sign_b),
    .o_bcd_hund(hund_b), .o_bcd_tens(tens_b), .o_bcd_ones(ones_b),
    .o_seg(seg_b), .o_an(an_b)
  );

  always #5 clk = ~clk;

  // Edges since reset release; with SCAN_DIV=4 the lit digit is (n/4)%4.
  always @(posedge clk or posedge rst) begin
    if (rst) ncyc <= 0;
    else     ncyc <= ncyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int idx, input bit s, input int mag);
    int h, t, o;
    h = mag / 100;
    t = (mag / 10) % 10;
    o = mag % 10;
    case (idx)
      3:       return s ? 7'h40 : 7'h00;
      2:       return (h == 0) ? 7'h00 : SEG_TBL[h];
      1:       return (h == 0 && t == 0) ? 7'h00 : SEG_TBL[t];
      default: return SEG_TBL[o];
    endcase
  endfunction

  task automatic check_result(input bit s, input int h, input int t, input int o);
    chk("sign", sign_a, s);
    chk("bcd_hund", hund_a, h);
    chk("bcd_tens", tens_a, t);
    chk("bcd_ones", ones_a, o);
    chk("sign_inv_inst", sign_b, s);
    chk("bcd_ones_inv_inst", ones_b, o);
  endtask

  task automatic convert(input logic [9:0] v);
    int lat;
    @(negedge clk);
    op    = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", busy_a, 1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 10) chk("busy_in_done_state", busy_a, 1);
      if (done_a) begin
        lat = k;
        break;
      end
    end
    chk("done_latency", lat, 11);
    chk("busy_with_done", busy_a, 0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", done_a, 0);
  endtask

  task automatic check_scan(input bit s, input int mag);
    int idx;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      idx = int'((ncyc / 4) % 4);
      chk("an", an_a, 4'b0001 << idx);
      chk("seg", seg_a, exp_seg(idx, s, mag));
      chk("an_active_low", an_b, ~(4'b0001 << idx) & 4'hF);
      chk("seg_active_low", seg_b, ~exp_seg(idx, s, mag) & 7'h7F);
    end
  endtask

  initial begin
    int lat, dones, val, mag;
    bit sgn;
    logic [9:0] v;

    vecs[0]  = '{10'd0,   1'b0, 0, 0, 0};
    vecs[1]  = '{10'h200, 1'b1, 5, 1, 2};
    vecs[2]  = '{10'd511, 1'b0, 5, 1, 1};
    vecs[3]  = '{10'h3F9, 1'b1, 0, 0, 7};
    vecs[4]  = '{10'd123, 1'b0, 1, 2, 3};
    vecs[5]  = '{10'h3D3, 1'b1, 0, 4, 5};
    vecs[6]  = '{10'd300, 1'b0, 3, 0, 0};
    vecs[7]  = '{10'd100, 1'b0, 1, 0, 0};
    vecs[8]  = '{10'h3F6, 1'b1, 0, 1, 0};
    vecs[9]  = '{10'h3FF, 1'b1, 0, 0, 1};
    vecs[10] = '{10'd9,   1'b0, 0, 0, 9};

    rst   = 1'b1;
    start = 1'b0;
    op    = '0;
    #12;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_sign", sign_a, 0);
    chk("rst_bcd", {hund_a, tens_a, ones_a}, 0);
    chk("rst_an", an_a, 4'b0001);
    chk("rst_seg", seg_a, 7'h3F);
    chk("rst_an_active_low", an_b, 4'b1110);
    chk("rst_seg_active_low", seg_b, 7'h40);
    @(negedge clk);
    rst = 1'b0;

    check_scan(1'b0, 0);

    for (int i = 0; i < 11; i++) begin
      convert(vecs[i].op);
      check_result(vecs[i].sgn, vecs[i].h, vecs[i].t, vecs[i].o);
      check_scan(vecs[i].sgn, vecs[i].h * 100 + vecs[i].t * 10 + vecs[i].o);
    end

    // start while busy: second request ignored, op not re-sampled
    @(negedge clk);
    op    = 10'd123;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin
        @(negedge clk);
        op    = 10'h3D3;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done_a) begin
        lat = k;
        break;
      end
    end
    chk("busy_start_latency", lat, 11);
    check_result(1'b0, 1, 2, 3);
    repeat (3) @(posedge clk);
    #1;
    chk("no_queued_conversion", busy_a, 0);
    convert(10'h3D3);
    check_result(1'b1, 0, 4, 5);

    // reset in the middle of the shift phase
    convert(10'd511);
    check_result(1'b0, 5, 1, 1);
    @(negedge clk);
    op    = 10'd300;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy_a, 0);
    chk("abort_done", done_a, 0);
    check_result(1'b0, 0, 0, 0);
    chk("abort_an", an_a, 4'b0001);
    chk("abort_seg", seg_a, 7'h3F);
    @(negedge clk);
    rst   = 1'b0;
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done_a || busy_a) dones++;
    end
    chk("abort_no_done", dones, 0);
    check_scan(1'b0, 0);

    // random operands against an arithmetic reference
    for (int r = 0; r < 30; r++) begin
      v   = 10'($urandom_range(0, 1023));
      val = (int'(v) >= 512) ? int'(v) - 1024 : int'(v);
      sgn = (val < 0);
      mag = sgn ? -val : val;
      convert(v);
      check_result(sgn, mag / 100, (mag / 10) % 10, mag % 10);
      if (r % 6 == 0) check_scan(sgn, mag);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
